// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared state encoding and default constants for the F1 random delay block
package f1_pkg;

  // Delay controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } f1_state_e;

  // Galois tap mask (right-shifting form) giving a maximal-length 16-bit sequence
  localparam logic [15:0] F1_LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] F1_LFSR_SEED    = 16'hACE1;
  localparam int          F1_RANGE_BITS   = 12;
  localparam int          F1_MIN_DELAY_MS = 500;

endpackage

// File: rtl/f1_random_delay_if.sv
// rtl/f1_random_delay_if.sv - sequencer-side request/response bundle for the random delay block
interface f1_random_delay_if #(
  parameter int CNT_W = 14
);
  logic             tick;
  logic             en_lfsr;
  logic             start_delay;
  logic             abort;
  logic             time_out;
  logic             busy;
  logic [CNT_W-1:0] delay_ms;

  // Sequencer side: drives requests, observes the delay status
  modport master (
    output tick, en_lfsr, start_delay, abort,
    input  time_out, busy, delay_ms
  );

  // Delay block side
  modport slave (
    input  tick, en_lfsr, start_delay, abort,
    output time_out, busy, delay_ms
  );
endinterface

// File: rtl/f1_lfsr.sv
// rtl/f1_lfsr.sv - free-running Galois LFSR that steps only while enabled
module f1_lfsr
  import f1_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = F1_LFSR_SEED,
  parameter logic [LFSR_W-1:0] TAPS      = F1_LFSR_TAPS
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] lfsr
);

  // An all-zero state would lock the register, so a zero seed falls back to 1
  localparam logic [LFSR_W-1:0] SEED_SAFE = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Next value: shift right and fold the taps in when a one drops out of the LSB
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
  end

  // Hold unless enabled; advances regardless of what the delay controller is doing
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_SAFE;
    end else if (en) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/f1_random_delay.sv
// rtl/f1_random_delay.sv - random hold-time generator; F1_DELAY_SNAPSHOT_EN keeps the last loaded delay on delay_ms
module f1_random_delay
  import f1_pkg::*;
#(
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = F1_LFSR_SEED,
  parameter int                RANGE_BITS   = F1_RANGE_BITS,
  parameter int                MIN_DELAY_MS = F1_MIN_DELAY_MS,
  parameter int                CNT_W        = 14
) (
  input  logic          sysclk,
  input  logic          rst_n,
  f1_random_delay_if.slave bus
);

  f1_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_q;
  logic             time_out_q;
  logic             busy_q;

  logic [LFSR_W-1:0] lfsr_w;
  logic [CNT_W-1:0]  load_d;
  logic              start_rise;
  logic              unused_lfsr_hi;

  f1_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_SEED (LFSR_SEED),
    .TAPS      (LFSR_W'(F1_LFSR_TAPS))
  ) u_lfsr (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .en     (bus.en_lfsr),
    .lfsr   (lfsr_w)
  );

  // Only the low RANGE_BITS of the LFSR form the random offset
  assign unused_lfsr_hi = ^lfsr_w[LFSR_W-1:RANGE_BITS];

  // Delay candidate: fixed minimum plus zero-extended random offset, sized to fit CNT_W
  always_comb begin
    load_d = CNT_W'(MIN_DELAY_MS) + {{(CNT_W-RANGE_BITS){1'b0}}, lfsr_w[RANGE_BITS-1:0]};
  end

  assign start_rise = bus.start_delay & ~start_q;

  // Controller FSM with registered time_out/busy; abort always beats the final tick
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      time_out_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      start_q    <= bus.start_delay;
      time_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (start_rise && !bus.abort) begin
            cnt_q   <= load_d;
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.abort) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bus.tick) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
              state_q    <= DONE;
              time_out_q <= 1'b1;
              busy_q     <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.time_out = time_out_q;
  assign bus.busy     = busy_q;

`ifdef F1_DELAY_SNAPSHOT_EN
  logic [CNT_W-1:0] delay_q;

  // Capture the delay on the IDLE->LOAD step and keep it for score display
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q <= '0;
    end else if (state_q == IDLE && start_rise && !bus.abort) begin
      delay_q <= load_d;
    end
  end

  assign bus.delay_ms = delay_q;
`else
  assign bus.delay_ms = '0;
`endif

endmodule

// File: tb/tb_f1_random_delay.sv
// tb/tb_f1_random_delay.sv - scoreboard bench for f1_random_delay
module tb_f1_random_delay;

  localparam int CNT_W = 14;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;

  always #5 sysclk = ~sysclk;

  f1_random_delay_if #(.CNT_W(CNT_W)) bus ();

  f1_random_delay #(
    .LFSR_W       (16),
    .LFSR_SEED    (16'hACE1),
    .RANGE_BITS   (12),
    .MIN_DELAY_MS (500),
    .CNT_W        (CNT_W)
  ) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int final_tick;
    int dly;
  } exp_t;

  exp_t sb[$];
  int   n_tests       = 0;
  int   n_fail        = 0;
  int   cyc           = 0;
  int   ticks_sent    = 0;
  int   last_tick_cyc = -10;

  always @(posedge sysclk) cyc <= cyc + 1;

  function automatic int exp_dms(input int d);
`ifdef F1_DELAY_SNAPSHOT_EN
    return d;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every time_out pulse must match the oldest expected expiry
  exp_t e;
  always @(negedge sysclk) begin
    if (rst_n === 1'b1 && bus.time_out === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_time_out: got pulse at cycle %0d (ticks %0d), expected none", cyc, ticks_sent);
      end else begin
        e = sb.pop_front();
        check("timeout_tick_count", ticks_sent, e.final_tick);
        check("timeout_latency", cyc, last_tick_cyc);
        check("timeout_delay_ms", 32'(bus.delay_ms), exp_dms(e.dly));
        check("timeout_busy", 32'(bus.busy), 0);
      end
    end
  end

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.tick        = 1'b0;
    bus.en_lfsr     = 1'b0;
    bus.start_delay = 1'b0;
    bus.abort       = 1'b0;
    sb.delete();
    repeat (2) @(posedge sysclk);
    #1;
    check("reset_time_out", 32'(bus.time_out), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_delay_ms", 32'(bus.delay_ms), 0);
    rst_n = 1'b1;
  endtask

  task automatic tick_n(input int n, input bit abort_last = 1'b0);
    for (int i = 0; i < n; i++) begin
      @(posedge sysclk); #1;
      bus.tick = 1'b1;
      if (abort_last && i == n - 1) bus.abort = 1'b1;
      ticks_sent++;
      last_tick_cyc = cyc + 1;
      @(posedge sysclk); #1;
      bus.tick  = 1'b0;
      bus.abort = 1'b0;
    end
  endtask

  // Fresh rising edge on start_delay; returns with the DUT in WAIT, start left high
  task automatic start(input int dly, input bit expect_pulse);
    @(posedge sysclk); #1;
    bus.start_delay = 1'b0;
    @(posedge sysclk); #1;
    bus.start_delay = 1'b1;
    @(posedge sysclk); #1;
    check("start_busy", 32'(bus.busy), 1);
    check("start_delay_ms", 32'(bus.delay_ms), exp_dms(dly));
    if (expect_pulse) begin
      e.final_tick = ticks_sent + dly;
      e.dly        = dly;
      sb.push_back(e);
    end
    @(posedge sysclk); #1;
  endtask

  initial begin
    // 1: seed only, LFSR held -> 500 + 0xCE1
    do_reset();
    start(3797, 1'b1);
    tick_n(3797);
    repeat (3) @(posedge sysclk);
    #1 check("t1_busy_after", 32'(bus.busy), 0);

    // 2: one LFSR step (0xACE1 -> 0xE270) -> 500 + 0x270
    do_reset();
    @(posedge sysclk); #1 bus.en_lfsr = 1'b1;
    @(posedge sysclk); #1 bus.en_lfsr = 1'b0;
    start(1124, 1'b1);
    tick_n(1124);
    repeat (3) @(posedge sysclk);

    // 3: start held high through expiry and 5000 more ticks -> one pulse only
    start(1124, 1'b1);
    tick_n(1124);
    tick_n(5000);
    #1 check("t3_busy_after", 32'(bus.busy), 0);

    // 4: abort coincides with the final tick -> no pulse, busy drops next cycle
    start(1124, 1'b0);
    tick_n(1123);
    check("t4_busy_before_abort", 32'(bus.busy), 1);
    tick_n(1, 1'b1);
    check("t4_busy_after_abort", 32'(bus.busy), 0);
    repeat (5) @(posedge sysclk);

    // 5: asynchronous reset mid-WAIT at cnt=200
    start(1124, 1'b1);
    tick_n(924);
    check("t5_busy_mid_wait", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("t5_async_busy", 32'(bus.busy), 0);
    check("t5_async_time_out", 32'(bus.time_out), 0);
    check("t5_async_delay_ms", 32'(bus.delay_ms), 0);
    bus.start_delay = 1'b0;
    @(posedge sysclk); #1 rst_n = 1'b1;
    tick_n(1200);
    check("t5_busy_idle", 32'(bus.busy), 0);

    // 6: second start edge mid-WAIT is ignored; single pulse at original expiry
    start(3797, 1'b1);
    tick_n(1000);
    @(posedge sysclk); #1 bus.start_delay = 1'b0;
    @(posedge sysclk); #1 bus.start_delay = 1'b1;
    @(posedge sysclk); #1;
    check("t6_busy_after_restart", 32'(bus.busy), 1);
    tick_n(2797);
    repeat (5) @(posedge sysclk);

    #1 check("pending_timeouts", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
